// File: rtl/cdb_arbiter.sv
// cdb_arbiter: shares the single CDB broadcast slot between the arithmetic unit
// and the load/store unit. Each producer has its own DEPTH-entry FIFO; every
// ready cycle one queued entry is popped and broadcast from registered outputs.
// Build option: define CDB_ARB_LS_PRIO_EN for fixed LS-first priority;
// the default build uses round-robin between the two sources.
module cdb_arbiter #(
    parameter int DEPTH  = 4,
    parameter int ROB_W  = 4,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              misbranch_flag,
    input  logic              arith_valid_in,
    input  logic [ROB_W-1:0]  arith_rob_id_in,
    input  logic [DATA_W-1:0] arith_result_in,
    output logic              arith_ready_out,
    input  logic              ls_valid_in,
    input  logic [ROB_W-1:0]  ls_rob_id_in,
    input  logic [DATA_W-1:0] ls_result_in,
    output logic              ls_ready_out,
    output logic              cdb_valid_out,
    output logic [ROB_W-1:0]  cdb_rob_id_out,
    output logic [DATA_W-1:0] cdb_result_out,
    output logic              cdb_src_out
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    // FIFO storage (data only; emptiness is defined by the pointers/counts)
    logic [ROB_W-1:0]  a_rob_q [DEPTH];
    logic [DATA_W-1:0] a_res_q [DEPTH];
    logic [ROB_W-1:0]  l_rob_q [DEPTH];
    logic [DATA_W-1:0] l_res_q [DEPTH];

    logic [PTR_W-1:0] a_wp_q, a_wp_d, a_rp_q, a_rp_d;
    logic [PTR_W-1:0] l_wp_q, l_wp_d, l_rp_q, l_rp_d;
    logic [CNT_W-1:0] a_cnt_q, a_cnt_d, l_cnt_q, l_cnt_d;
    logic             last_grant_q, last_grant_d;   // 1 = LS won last grant

    logic              cdb_valid_q, cdb_valid_d;
    logic [ROB_W-1:0]  cdb_rob_q, cdb_rob_d;
    logic [DATA_W-1:0] cdb_res_q, cdb_res_d;
    logic              cdb_src_q, cdb_src_d;

    logic a_ne, l_ne, gnt_a, gnt_l;
    logic a_push, l_push, a_pop, l_pop;

    assign arith_ready_out = (a_cnt_q < DEPTH_C);
    assign ls_ready_out    = (l_cnt_q < DEPTH_C);
    assign a_ne            = (a_cnt_q != '0);
    assign l_ne            = (l_cnt_q != '0);

    // A flush discards same-cycle offers; id 0 means "no producer" and is dropped
    assign a_push = rdy & ~misbranch_flag & arith_valid_in & arith_ready_out
                    & (arith_rob_id_in != '0);
    assign l_push = rdy & ~misbranch_flag & ls_valid_in & ls_ready_out
                    & (ls_rob_id_in != '0);
    assign a_pop  = rdy & ~misbranch_flag & gnt_a;
    assign l_pop  = rdy & ~misbranch_flag & gnt_l;

    // Grant selection from pre-edge FIFO occupancy
    always_comb begin
        gnt_a = 1'b0;
        gnt_l = 1'b0;
`ifdef CDB_ARB_LS_PRIO_EN
        if (l_ne)      gnt_l = 1'b1;
        else if (a_ne) gnt_a = 1'b1;
`else
        if (a_ne && l_ne) begin
            if (last_grant_q) gnt_a = 1'b1;
            else              gnt_l = 1'b1;
        end else if (a_ne) begin
            gnt_a = 1'b1;
        end else if (l_ne) begin
            gnt_l = 1'b1;
        end
`endif
    end

    // Next-state for pointers, counts, grant history and the broadcast register
    always_comb begin
        a_wp_d       = a_wp_q;
        a_rp_d       = a_rp_q;
        a_cnt_d      = a_cnt_q;
        l_wp_d       = l_wp_q;
        l_rp_d       = l_rp_q;
        l_cnt_d      = l_cnt_q;
        last_grant_d = last_grant_q;
        cdb_valid_d  = cdb_valid_q;
        cdb_rob_d    = cdb_rob_q;
        cdb_res_d    = cdb_res_q;
        cdb_src_d    = cdb_src_q;
        if (misbranch_flag) begin
            a_wp_d       = '0;
            a_rp_d       = '0;
            a_cnt_d      = '0;
            l_wp_d       = '0;
            l_rp_d       = '0;
            l_cnt_d      = '0;
            last_grant_d = 1'b1;
            cdb_valid_d  = 1'b0;
            cdb_rob_d    = '0;
            cdb_res_d    = '0;
            cdb_src_d    = 1'b0;
        end else if (rdy) begin
            if (a_push) a_wp_d = a_wp_q + 1'b1;
            if (a_pop)  a_rp_d = a_rp_q + 1'b1;
            if (l_push) l_wp_d = l_wp_q + 1'b1;
            if (l_pop)  l_rp_d = l_rp_q + 1'b1;
            a_cnt_d = a_cnt_q + CNT_W'(a_push) - CNT_W'(a_pop);
            l_cnt_d = l_cnt_q + CNT_W'(l_push) - CNT_W'(l_pop);
            if (gnt_a) begin
                cdb_valid_d  = 1'b1;
                cdb_rob_d    = a_rob_q[a_rp_q];
                cdb_res_d    = a_res_q[a_rp_q];
                cdb_src_d    = 1'b0;
                last_grant_d = 1'b0;
            end else if (gnt_l) begin
                cdb_valid_d  = 1'b1;
                cdb_rob_d    = l_rob_q[l_rp_q];
                cdb_res_d    = l_res_q[l_rp_q];
                cdb_src_d    = 1'b1;
                last_grant_d = 1'b1;
            end else begin
                cdb_valid_d  = 1'b0;
                cdb_rob_d    = '0;
                cdb_res_d    = '0;
                cdb_src_d    = 1'b0;
            end
        end
    end

    // State and broadcast registers with asynchronous active-low clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_wp_q       <= '0;
            a_rp_q       <= '0;
            a_cnt_q      <= '0;
            l_wp_q       <= '0;
            l_rp_q       <= '0;
            l_cnt_q      <= '0;
            last_grant_q <= 1'b1;
            cdb_valid_q  <= 1'b0;
            cdb_rob_q    <= '0;
            cdb_res_q    <= '0;
            cdb_src_q    <= 1'b0;
        end else begin
            a_wp_q       <= a_wp_d;
            a_rp_q       <= a_rp_d;
            a_cnt_q      <= a_cnt_d;
            l_wp_q       <= l_wp_d;
            l_rp_q       <= l_rp_d;
            l_cnt_q      <= l_cnt_d;
            last_grant_q <= last_grant_d;
            cdb_valid_q  <= cdb_valid_d;
            cdb_rob_q    <= cdb_rob_d;
            cdb_res_q    <= cdb_res_d;
            cdb_src_q    <= cdb_src_d;
        end
    end

    // FIFO entry writes; storage needs no reset
    always_ff @(posedge clk) begin
        if (a_push) begin
            a_rob_q[a_wp_q] <= arith_rob_id_in;
            a_res_q[a_wp_q] <= arith_result_in;
        end
        if (l_push) begin
            l_rob_q[l_wp_q] <= ls_rob_id_in;
            l_res_q[l_wp_q] <= ls_result_in;
        end
    end

    assign cdb_valid_out  = cdb_valid_q;
    assign cdb_rob_id_out = cdb_rob_q;
    assign cdb_result_out = cdb_res_q;
    assign cdb_src_out    = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter; expectations follow the build option
// CDB_ARB_LS_PRIO_EN when it is defined.
module tb_cdb_arbiter;

    localparam int ROB_W  = 4;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              rdy;
    logic              misbranch_flag;
    logic              arith_valid_in;
    logic [ROB_W-1:0]  arith_rob_id_in;
    logic [DATA_W-1:0] arith_result_in;
    logic              arith_ready_out;
    logic              ls_valid_in;
    logic [ROB_W-1:0]  ls_rob_id_in;
    logic [DATA_W-1:0] ls_result_in;
    logic              ls_ready_out;
    logic              cdb_valid_out;
    logic [ROB_W-1:0]  cdb_rob_id_out;
    logic [DATA_W-1:0] cdb_result_out;
    logic              cdb_src_out;

    int n_vec = 0;
    int n_err = 0;

    cdb_arbiter #(.DEPTH(4), .ROB_W(ROB_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .misbranch_flag(misbranch_flag),
        .arith_valid_in(arith_valid_in), .arith_rob_id_in(arith_rob_id_in),
        .arith_result_in(arith_result_in), .arith_ready_out(arith_ready_out),
        .ls_valid_in(ls_valid_in), .ls_rob_id_in(ls_rob_id_in),
        .ls_result_in(ls_result_in), .ls_ready_out(ls_ready_out),
        .cdb_valid_out(cdb_valid_out), .cdb_rob_id_out(cdb_rob_id_out),
        .cdb_result_out(cdb_result_out), .cdb_src_out(cdb_src_out)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        rdy = 1'b1; misbranch_flag = 1'b0;
        arith_valid_in = 1'b0; arith_rob_id_in = '0; arith_result_in = '0;
        ls_valid_in = 1'b0; ls_rob_id_in = '0; ls_result_in = '0;
    endtask

    task automatic offer_a(input int rob);
        arith_valid_in = 1'b1; arith_rob_id_in = ROB_W'(rob);
        arith_result_in = 32'hA000 + rob;
    endtask

    task automatic offer_l(input int rob);
        ls_valid_in = 1'b1; ls_rob_id_in = ROB_W'(rob);
        ls_result_in = 32'hB000 + rob;
    endtask

    task automatic flush;
        misbranch_flag = 1'b1; tick; misbranch_flag = 1'b0;
    endtask

    task automatic test_reset;
        logic [37:0] exp;
        idle_inputs; rst = 1'b0;
        repeat (2) tick;
        n_vec++;
        if ({cdb_valid_out, cdb_rob_id_out, cdb_result_out, cdb_src_out, arith_ready_out, ls_ready_out}
            !== {1'b0, 4'd0, 32'd0, 1'b0, 2'b11}) begin
            n_err++; $display("FAIL reset_state got v=%0b rob=%0d res=%h src=%0b rdy=%0b%0b want 0/0/0/0 ready 11",
                cdb_valid_out, cdb_rob_id_out, cdb_result_out, cdb_src_out, arith_ready_out, ls_ready_out);
        end
        rst = 1'b1; tick;
        offer_a(1); offer_l(5); tick;
        offer_a(2); offer_l(6); tick;
        idle_inputs;
`ifdef CDB_ARB_LS_PRIO_EN
        exp = {1'b1, 4'd5, 32'hB005, 1'b1};
`else
        exp = {1'b1, 4'd1, 32'hA001, 1'b0};
`endif
        n_vec++;
        if ({cdb_valid_out, cdb_rob_id_out, cdb_result_out, cdb_src_out} !== exp) begin
            n_err++; $display("FAIL reset_prefill got rob=%0d res=%h want %h", cdb_rob_id_out, cdb_result_out, exp);
        end
        rst = 1'b0; #1;
        n_vec++;
        if ({cdb_valid_out, cdb_rob_id_out, cdb_result_out, cdb_src_out, arith_ready_out, ls_ready_out}
            !== {1'b0, 4'd0, 32'd0, 1'b0, 2'b11}) begin
            n_err++; $display("FAIL reset_async got v=%0b rob=%0d res=%h src=%0b want all 0 ready 11",
                cdb_valid_out, cdb_rob_id_out, cdb_result_out, cdb_src_out);
        end
        tick; rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick;
            n_vec++;
            if (cdb_valid_out !== 1'b0) begin
                n_err++; $display("FAIL reset_lost cyc%0d got valid=%0b rob=%0d want valid 0", c, cdb_valid_out, cdb_rob_id_out);
            end
        end
    endtask

    task automatic test_single;
        idle_inputs;
        arith_valid_in = 1'b1; arith_rob_id_in = 4'd3; arith_result_in = 32'h0000_1234;
        tick; idle_inputs;
        n_vec++;
        if (cdb_valid_out !== 1'b0) begin
            n_err++; $display("FAIL single_latency got valid=%0b want 0", cdb_valid_out);
        end
        tick;
        n_vec++;
        if ({cdb_valid_out, cdb_rob_id_out, cdb_result_out, cdb_src_out} !== {1'b1, 4'd3, 32'h1234, 1'b0}) begin
            n_err++; $display("FAIL single_bcast got v=%0b rob=%0d res=%h src=%0b want 1/3/1234/0",
                cdb_valid_out, cdb_rob_id_out, cdb_result_out, cdb_src_out);
        end
        tick;
        n_vec++;
        if ({cdb_valid_out, cdb_rob_id_out, cdb_result_out, cdb_src_out} !== {1'b0, 4'd0, 32'd0, 1'b0}) begin
            n_err++; $display("FAIL single_idle got v=%0b rob=%0d res=%h want all 0",
                cdb_valid_out, cdb_rob_id_out, cdb_result_out);
        end
    endtask

    task automatic test_interleave;
        int exp_rob [8];
        int got_rob [8];
        int got_src [8];
        logic [31:0] got_res [8];
        int got = 0;
`ifdef CDB_ARB_LS_PRIO_EN
        exp_rob = '{5, 6, 7, 8, 1, 2, 3, 4};
`else
        exp_rob = '{1, 5, 2, 6, 3, 7, 4, 8};
`endif
        idle_inputs; flush;
        for (int c = 0; c < 24 && got < 8; c++) begin
            idle_inputs;
            if (c < 4) begin offer_a(c + 1); offer_l(c + 5); end
            tick;
            if (cdb_valid_out === 1'b1 && got < 8) begin
                got_rob[got] = int'(cdb_rob_id_out); got_src[got] = int'(cdb_src_out);
                got_res[got] = cdb_result_out; got++;
            end
        end
        idle_inputs;
        n_vec++;
        if (got != 8) begin
            n_err++; $display("FAIL interleave_count got %0d broadcasts want 8", got);
        end
        for (int k = 0; k < got; k++) begin
            n_vec++;
            if (got_rob[k] != exp_rob[k] || got_src[k] != int'(exp_rob[k] >= 5)
                || got_res[k] !== ((exp_rob[k] >= 5 ? 32'hB000 : 32'hA000) + exp_rob[k])) begin
                n_err++; $display("FAIL interleave_%0d got rob=%0d src=%0d res=%h want rob=%0d",
                    k, got_rob[k], got_src[k], got_res[k], exp_rob[k]);
            end
        end
    endtask

    task automatic test_backpressure;
        int qa[$];
        int ql[$];
        int an = 0, ln = 0, arob, lrob, exp;
        bit a_acc, l_acc, saw_full = 0;
        idle_inputs; flush;
        for (int c = 0; c < 16; c++) begin
            arob = (an % 7) + 1; lrob = (ln % 7) + 8;
            offer_a(arob); offer_l(lrob);
            a_acc = arith_ready_out; l_acc = ls_ready_out;
            if (!arith_ready_out) saw_full = 1;
            tick;
            if (a_acc) begin qa.push_back(arob); an++; end
            if (l_acc) begin ql.push_back(lrob); ln++; end
            if (cdb_valid_out === 1'b1) begin
                n_vec++;
                if (cdb_src_out) exp = (ql.size() > 0) ? ql.pop_front() : -1;
                else             exp = (qa.size() > 0) ? qa.pop_front() : -1;
                if (int'(cdb_rob_id_out) != exp
                    || cdb_result_out !== ((cdb_src_out ? 32'hB000 : 32'hA000) + exp)) begin
                    n_err++; $display("FAIL bp_order got rob=%0d src=%0b res=%h want rob=%0d",
                        cdb_rob_id_out, cdb_src_out, cdb_result_out, exp);
                end
            end
        end
        idle_inputs;
        n_vec++;
        if (!saw_full) begin
            n_err++; $display("FAIL bp_ready got arith_ready never 0 want 0 when full");
        end
        for (int c = 0; c < 40 && (qa.size() + ql.size()) > 0; c++) begin
            tick;
            if (cdb_valid_out === 1'b1) begin
                n_vec++;
                if (cdb_src_out) exp = (ql.size() > 0) ? ql.pop_front() : -1;
                else             exp = (qa.size() > 0) ? qa.pop_front() : -1;
                if (int'(cdb_rob_id_out) != exp) begin
                    n_err++; $display("FAIL bp_drain got rob=%0d src=%0b want rob=%0d",
                        cdb_rob_id_out, cdb_src_out, exp);
                end
            end
        end
        n_vec++;
        if ((qa.size() + ql.size()) != 0) begin
            n_err++; $display("FAIL bp_left got %0d undelivered want 0", qa.size() + ql.size());
        end
        tick;
    endtask

`ifdef CDB_ARB_LS_PRIO_EN
    task automatic test_ls_prio;
        int a_next = 1, n_arith = 0;
        int got [5];
        bit acc;
        idle_inputs; flush;
        for (int c = 0; c < 12; c++) begin
            offer_a(a_next); offer_l(8 + (c % 8));
            acc = arith_ready_out;
            tick;
            if (acc) a_next++;
            if (cdb_valid_out === 1'b1 && cdb_src_out === 1'b0 && n_arith < 5) begin
                got[n_arith] = int'(cdb_rob_id_out); n_arith++;
            end
        end
        n_vec++;
        if (a_next != 5 || arith_ready_out !== 1'b0 || n_arith != 0) begin
            n_err++; $display("FAIL prio_block got accepted=%0d ready=%0b arith_bcast=%0d want 4/0/0",
                a_next - 1, arith_ready_out, n_arith);
        end
        ls_valid_in = 1'b0;
        for (int c = 0; c < 20 && n_arith < 5; c++) begin
            acc = arith_ready_out & arith_valid_in;
            tick;
            if (acc) begin
                a_next++;
                if (a_next > 5) arith_valid_in = 1'b0; else offer_a(a_next);
            end
            if (cdb_valid_out === 1'b1 && cdb_src_out === 1'b0 && n_arith < 5) begin
                got[n_arith] = int'(cdb_rob_id_out); n_arith++;
            end
        end
        idle_inputs;
        n_vec++;
        if (n_arith != 5) begin
            n_err++; $display("FAIL prio_count got %0d arith broadcasts want 5", n_arith);
        end
        for (int k = 0; k < n_arith; k++) begin
            n_vec++;
            if (got[k] != k + 1) begin
                n_err++; $display("FAIL prio_order_%0d got rob=%0d want %0d", k, got[k], k + 1);
            end
        end
        repeat (3) tick;
    endtask
`endif

    task automatic test_zero_and_flush;
        idle_inputs;
        arith_valid_in = 1'b1; arith_rob_id_in = 4'd0; arith_result_in = 32'hDEAD;
        tick; idle_inputs;
        for (int c = 0; c < 3; c++) begin
            tick;
            n_vec++;
            if (cdb_valid_out !== 1'b0 || arith_ready_out !== 1'b1) begin
                n_err++; $display("FAIL zero_id cyc%0d got valid=%0b ready=%0b want 0/1", c, cdb_valid_out, arith_ready_out);
            end
        end
        offer_a(10); offer_l(11); tick;
        offer_a(12); offer_l(13); tick;
        n_vec++;
        if (cdb_valid_out !== 1'b1) begin
            n_err++; $display("FAIL flush_pre got valid=%0b want 1", cdb_valid_out);
        end
        offer_a(14); offer_l(15); misbranch_flag = 1'b1;
        tick; idle_inputs;
        n_vec++;
        if ({cdb_valid_out, cdb_rob_id_out, cdb_result_out, cdb_src_out, arith_ready_out, ls_ready_out}
            !== {1'b0, 4'd0, 32'd0, 1'b0, 2'b11}) begin
            n_err++; $display("FAIL flush_state got v=%0b rob=%0d res=%h src=%0b rdy=%0b%0b want 0 ready 11",
                cdb_valid_out, cdb_rob_id_out, cdb_result_out, cdb_src_out, arith_ready_out, ls_ready_out);
        end
        for (int c = 0; c < 6; c++) begin
            tick;
            n_vec++;
            if (cdb_valid_out !== 1'b0) begin
                n_err++; $display("FAIL flush_gone cyc%0d got valid=1 rob=%0d want valid 0", c, cdb_rob_id_out);
            end
        end
    endtask

    task automatic test_freeze;
        logic [37:0] hold;
        int exp2 [2];
`ifdef CDB_ARB_LS_PRIO_EN
        hold = {1'b1, 4'd14, 32'hB01E, 1'b1};
        exp2 = '{4, 5};
`else
        hold = {1'b1, 4'd4, 32'hA014, 1'b0};
        exp2 = '{14, 5};
`endif
        idle_inputs;
        offer_a(4); arith_result_in = 32'hA014; offer_l(14); ls_result_in = 32'hB01E; tick;
        idle_inputs; offer_a(5); tick;
        rdy = 1'b0; offer_a(6); offer_l(15);
        for (int c = 0; c < 4; c++) begin
            n_vec++;
            if ({cdb_valid_out, cdb_rob_id_out, cdb_result_out, cdb_src_out} !== hold
                || arith_ready_out !== 1'b1 || ls_ready_out !== 1'b1) begin
                n_err++; $display("FAIL freeze_hold cyc%0d got rob=%0d res=%h src=%0b want %h",
                    c, cdb_rob_id_out, cdb_result_out, cdb_src_out, hold);
            end
            if (c < 3) tick;
        end
        idle_inputs;
        for (int k = 0; k < 2; k++) begin
            tick;
            n_vec++;
            if (cdb_valid_out !== 1'b1 || int'(cdb_rob_id_out) != exp2[k]) begin
                n_err++; $display("FAIL freeze_resume_%0d got v=%0b rob=%0d want 1/%0d",
                    k, cdb_valid_out, cdb_rob_id_out, exp2[k]);
            end
        end
        tick;
        n_vec++;
        if (cdb_valid_out !== 1'b0) begin
            n_err++; $display("FAIL freeze_nopush got valid=1 rob=%0d want valid 0", cdb_rob_id_out);
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_interleave;
        test_backpressure;
`ifdef CDB_ARB_LS_PRIO_EN
        test_ls_prio;
`endif
        test_zero_and_flush;
        test_freeze;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
